// File: rtl/mips_hazard_pkg.sv
// Shared types and helpers for the MIPS pipeline hazard scoreboard.
package mips_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_E    = 2'd1,
    FWD_M    = 2'd2,
    FWD_W    = 2'd3
  } fwd_sel_e;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } hz_entry_t;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == '0) ? '0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_operand_check.sv
// Per-operand dependency check against the E/M/W entries.
// HAZARD_FWD_EN selects forwarding vs. stall-only interlock.
module hazard_operand_check
  import mips_hazard_pkg::*;
(
  input  logic [4:0] op_reg,
  input  logic [1:0] op_tuse,
  input  hz_entry_t  e_ent,
  input  hz_entry_t  m_ent,
  input  hz_entry_t  w_ent,
  output logic       stall_op,
  output logic [1:0] fwd_sel
);

  logic used;
  logic hit_e;
  logic hit_m;

  assign used  = (op_tuse != TUSE_NONE);
  assign hit_e = (op_reg != '0) && (op_reg == e_ent.dst);
  assign hit_m = (op_reg != '0) && (op_reg == m_ent.dst);

`ifdef HAZARD_FWD_EN
  logic hit_w;
  assign hit_w = (op_reg != '0) && (op_reg == w_ent.dst);

  // Youngest match decides; an older producer of the same register is stale.
  always_comb begin
    stall_op = 1'b0;
    fwd_sel  = FWD_NONE;
    if (hit_e) begin
      stall_op = used && (e_ent.tnew > op_tuse);
      if (e_ent.tnew == '0) fwd_sel = FWD_E;
    end else if (hit_m) begin
      stall_op = used && (m_ent.tnew > op_tuse);
      if (m_ent.tnew == '0) fwd_sel = FWD_M;
    end else if (hit_w) begin
      stall_op = used && (w_ent.tnew > op_tuse);
      if (w_ent.tnew == '0) fwd_sel = FWD_W;
    end
  end
`else
  // W is covered by the write-before-read register file.
  logic unused_fields;
  assign unused_fields = ^{w_ent, e_ent.tnew, m_ent.tnew};
  assign stall_op = used && (hit_e || hit_m);
  assign fwd_sel  = FWD_NONE;
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forwarding controller tracking in-flight writes in E, M and W.
// Define HAZARD_FWD_EN to enable forwarding; otherwise stall-only interlock.
module hazard_scoreboard
  import mips_hazard_pkg::*;
#(
  parameter int TUSE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  input  logic [TUSE_W-1:0] d_tuse_rs,
  input  logic [TUSE_W-1:0] d_tuse_rt,
  input  logic [4:0]        d_dst,
  input  logic [TUSE_W-1:0] d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt
);

  hz_entry_t  e_ent, m_ent, w_ent;
  logic [4:0] e_rs, e_rt;
  logic       stall_rs, stall_rt;
  logic       e_rs_stall_unused, e_rt_stall_unused;

  assign stall = d_valid & (stall_rs | stall_rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ent <= '0;
      m_ent <= '0;
      w_ent <= '0;
      e_rs  <= '0;
      e_rt  <= '0;
    end else begin
      if (stall || !d_valid) begin
        e_ent <= '0;
        e_rs  <= '0;
        e_rt  <= '0;
      end else begin
        e_ent <= '{dst: d_dst, tnew: d_tnew};
        e_rs  <= d_rs;
        e_rt  <= d_rt;
      end
      m_ent <= '{dst: e_ent.dst, tnew: sat_dec(e_ent.tnew)};
      w_ent <= '{dst: m_ent.dst, tnew: sat_dec(m_ent.tnew)};
    end
  end

  hazard_operand_check u_d_rs (
    .op_reg(d_rs), .op_tuse(d_tuse_rs),
    .e_ent(e_ent), .m_ent(m_ent), .w_ent(w_ent),
    .stall_op(stall_rs), .fwd_sel(fwd_d_rs)
  );

  hazard_operand_check u_d_rt (
    .op_reg(d_rt), .op_tuse(d_tuse_rt),
    .e_ent(e_ent), .m_ent(m_ent), .w_ent(w_ent),
    .stall_op(stall_rt), .fwd_sel(fwd_d_rt)
  );

  // E-operand selects: E entry masked so E never forwards to itself.
  hazard_operand_check u_e_rs (
    .op_reg(e_rs), .op_tuse(TUSE_NONE),
    .e_ent('0), .m_ent(m_ent), .w_ent(w_ent),
    .stall_op(e_rs_stall_unused), .fwd_sel(fwd_e_rs)
  );

  hazard_operand_check u_e_rt (
    .op_reg(e_rt), .op_tuse(TUSE_NONE),
    .e_ent('0), .m_ent(m_ent), .w_ent(w_ent),
    .stall_op(e_rt_stall_unused), .fwd_sel(fwd_e_rt)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow HAZARD_FWD_EN.
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [8:0] outs;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  assign outs = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};

  hazard_scoreboard #(.TUSE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .stall(stall),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt)
  );

  function automatic logic [8:0] ov(input logic st, input logic [1:0] a, b, c, d);
    return {st, a, b, c, d};
  endfunction

  function automatic logic [1:0] fw(input logic [1:0] v);
    return FWD ? v : 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt,
                       input logic [4:0] dst, input logic [1:0] tnew);
    d_valid = v; d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    d_dst = dst; d_tnew = tnew;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic bubble();
    set_d(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
  endtask

  task automatic flush();
    bubble();
    repeat (3) nxt();
  endtask

  // Counts stalled cycles of the held D instruction; bounded wait.
  task automatic count_stall(input string tag, input int exp_n);
    int n = 0;
    smp();
    while (stall === 1'b1 && n < 8) begin
      n++;
      nxt();
      smp();
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    rst_n = 1'b0;
    set_d(1'b1, 5'd8, 2'd0, 5'd31, 2'd0, 5'd8, 2'd2);
    #3;
    chk("reset_outs", outs, ov(0, 0, 0, 0, 0));
    nxt(); nxt();
    smp();
    chk("reset_held", outs, ov(0, 0, 0, 0, 0));
    nxt();
    rst_n = 1'b1;
    set_d(1'b0, 5'd5, 2'd0, 5'd5, 2'd0, 5'd5, 2'd0);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk($sformatf("post_reset_%0d", i), outs, ov(0, 0, 0, 0, 0));
      nxt();
    end
    flush();

    // lw $8 ; addu $11,$8,$8 (tuse 1)
    set_d(1'b1, 5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2);
    smp(); chk("lw_issue", outs, ov(0, 0, 0, 0, 0));
    nxt();
    set_d(1'b1, 5'd8, 2'd1, 5'd8, 2'd1, 5'd11, 2'd1);
    count_stall("lw_addu_stall", FWD ? 1 : 2);
    chk("lw_addu_fwd_d", outs, ov(0, 0, 0, 0, 0));
    nxt();
    bubble();
    smp(); chk("lw_addu_fwd_e", outs, ov(0, 0, 0, fw(2'd3), fw(2'd3)));
    flush();

    // lw $8 ; beq $8,$9 (tuse 0)
    set_d(1'b1, 5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2);
    smp(); chk("lw2_issue", outs, ov(0, 0, 0, 0, 0));
    nxt();
    set_d(1'b1, 5'd8, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0);
    count_stall("lw_beq_stall", 2);
    chk("lw_beq_fwd_w", outs, ov(0, fw(2'd3), 0, 0, 0));
    flush();

    // ori $9 ; jr $9
    set_d(1'b1, 5'd0, 2'd1, 5'd0, 2'd3, 5'd9, 2'd1);
    nxt();
    set_d(1'b1, 5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    count_stall("ori_jr_stall", FWD ? 1 : 2);
    chk("ori_jr_fwd_m", outs, ov(0, fw(2'd2), 0, 0, 0));
    flush();

    // jal ; jr $31 ; then a dst=$0 producer and jr $0
    set_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0);
    nxt();
    set_d(1'b1, 5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    count_stall("jal_jr_stall", FWD ? 0 : 2);
    chk("jal_jr_fwd_e", outs, ov(0, fw(2'd1), 0, 0, 0));
    nxt();
    set_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2);
    smp(); chk("jr31_in_e_fwd_m", outs, ov(0, 0, 0, fw(2'd2), 0));
    nxt();
    set_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    count_stall("r0_stall", 0);
    chk("r0_fwd", outs, ov(0, 0, 0, 0, 0));
    flush();

    // ori $10 ; lui $10 ; addu rs=$10 (tuse 1): youngest producer wins
    set_d(1'b1, 5'd0, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1);
    nxt();
    set_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd1);
    smp(); chk("lui_issue", outs, ov(0, 0, 0, 0, 0));
    nxt();
    set_d(1'b1, 5'd10, 2'd1, 5'd0, 2'd1, 5'd12, 2'd1);
    count_stall("dup_dst_stall", FWD ? 0 : 2);
    chk("dup_dst_fwd_d", outs, ov(0, 0, 0, 0, 0));
    nxt();
    bubble();
    smp(); chk("dup_dst_fwd_e", outs, ov(0, 0, 0, fw(2'd2), 0));
    flush();

    // Reset asserted in the middle of a lw/beq stall
    set_d(1'b1, 5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2);
    nxt();
    set_d(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    smp(); chk("pre_reset_stall", stall, 1);
    #1 rst_n = 1'b0;
    #1 chk("mid_stall_reset", outs, ov(0, 0, 0, 0, 0));
    nxt();
    rst_n = 1'b1;
    smp(); chk("after_reset_no_stall", outs, ov(0, 0, 0, 0, 0));
    flush();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Stall and forwarding controller for the five-stage MIPS pipeline. It tracks every in-flight register write in E, M and W as a destination register plus a Tnew countdown (cycles until the result exists). Each cycle it compares D-stage source operands and their Tuse against these entries. It then drives the F/D hold and E bubble signal, plus forwarding selects for D-stage and E-stage operand muxes.

## Interface
Parameters:
- TUSE_W, 2, width of Tuse/Tnew fields; value 3 in a Tuse field means "operand not read"

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_valid  in  1  D stage holds a real instruction (0 = bubble)
- d_rs, d_rt  in  5 each  D-stage source register numbers
- d_tuse_rs, d_tuse_rt  in  2 each  cycles from D until operand is consumed (0 = at D, 1 = at E, 3 = unused)
- d_dst  in  5  destination register written by D instruction (0 = none)
- d_tnew  in  2  Tnew the instruction will have on entering E (lw 2, ALU/ori/lui 1, jal 0)
- stall  out  1  hold PC and F/D register, insert bubble into E
- fwd_d_rs, fwd_d_rt  out  2 each  D-operand source: 0 regfile, 1 E, 2 M, 3 W
- fwd_e_rs, fwd_e_rt  out  2 each  E-operand source: 0 pipeline reg, 2 M, 3 W

## Operation
- State: entries E, M, W, each {dst[4:0], tnew[1:0]}. E also holds registered rs/rt of the instruction in E. A bubble is dst=0, tnew=0.
- Update on each rising edge:
  - If stall, or if d_valid=0, E <= bubble. Otherwise E <= {d_dst, d_tnew, d_rs, d_rt}.
  - M <= {E.dst, sat_dec(E.tnew)}.
  - W <= {M.dst, sat_dec(M.tnew)}.
  - sat_dec(0)=0.
- Match: an operand r matches stage X when r≠0 and r==X.dst. The youngest match wins (E over M over W). Older matches for the same r are ignored.
- Stall, per operand, with FWD_EN defined: stall when tuse≠3 and the youngest match has tnew > tuse. stall = d_valid & (stall_rs | stall_rt).
- D forwarding: the select is the stage of the youngest match with tnew==0. It is 0 if there is no match, or if the youngest match has tnew>0; stall then covers that case.
- E forwarding: the select is computed from E's registered rs/rt against M, then W. The youngest match with tnew==0 gives 2 or 3, otherwise 0. E never forwards from itself.
- Register 0 never matches, never stalls and never forwards.

## Timing
- stall and all fwd_* are combinational from the inputs and current state, valid in the same cycle. There is no registered latency.
- A stall lasts exactly until the blocking entry's tnew drops to tuse or below. Example: lw followed by a dependent add with tuse 1 stalls 1 cycle; with tuse 0 it stalls 2 cycles.
- Reset: asynchronous assert immediately clears all entries to bubble. Outputs then read stall=0 and all fwd_*=0. Deassert is synchronous to clk through the standard reset synchroniser upstream.
- Reset asserted mid-stall drops stall in the same cycle.
- Simultaneous W write and D read of the same register with FWD_EN defined: the select is 3 (W).

## Configuration
- HAZARD_FWD_EN defined: forwarding as above.
- Not defined:
  - All fwd_* outputs are tied to 0.
  - stall is asserted for any valid D operand (tuse≠3) that matches E or M, whatever the tnew.
  - W matches do not stall; the register file is write-before-read.

## Structure
- Package mips_hazard_pkg holds:
  - FWD_NONE=0, FWD_E=1, FWD_M=2, FWD_W=3.
  - TUSE_NONE=3.
  - Packed struct hz_entry_t {dst, tnew}.
  - Function sat_dec.
- Sub-module hazard_operand_check takes one operand, its tuse and the three entries, and returns stall_op and fwd_sel. It is instantiated twice for D (rs, rt). The E selects use the same logic with the E entry masked.

## Test plan
- Reset: drive rst_n=0 with garbage on the inputs → stall=0, all fwd_*=0. Entries stay clear for 3 cycles after release with d_valid=0.
- lw $8 (d_tnew=2), then addu rs=$8 tuse=1 → stall=1 for exactly 1 cycle. Next cycle: fwd_d_rs=0, and once the add reaches E, fwd_e_rs=3 (W).
- lw $8, then beq rs=$8 tuse=0 → stall high 2 cycles. Then fwd_d_rs=3.
- ori $9 (tnew 1), then jr $9 tuse=0 → 1-cycle stall. Then fwd_d_rs=2.
- jal (d_dst=31, tnew 0), then jr $31 tuse=0 → no stall, fwd_d_rs=1. Repeat with rs=$0 and d_dst=0 → no stall, fwd 0.
- Back-to-back writes to $10 (ori, then lui), then read $10 tuse=1 → E entry wins and fwd_e_rs=2, not W. With HAZARD_FWD_EN undefined, the same sequence stalls until no E/M match remains.
